// File: rtl/uart_byte_receiver_pkg.sv
// Shared types and helpers for the UART byte receiver.
package uart_byte_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Clocks per oversample tick, never below 1.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned d;
    d = clk_freq / (baud_rate * oversample);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Receiver-facing signal bundle: serial line in, byte/strobe/status out.
interface uart_byte_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       dataReady;
  logic       frameError;
  logic       busy;

  modport master (output rx, input data, input dataReady, input frameError, input busy);
  modport slave  (input rx, output data, output dataReady, output frameError, output busy);
endinterface

// File: rtl/uart_byte_receiver_baud_tick.sv
// Oversample tick generator; counter parked at zero while disabled so the
// tick phase follows the start-bit edge.
module uart_baud_tick #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  import uart_byte_receiver_pkg::*;

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (!enable)         cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with 2-flop input synchronizer.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting on data/stop bits.
module uart_byte_receiver
  import uart_byte_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic           clk,
  input logic           rst,
  uart_byte_receiver_if.slave bus
);

  localparam int unsigned SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);

  uart_rx_state_t  state, state_n;
  logic [SC_W-1:0] sc, sc_n;
  logic [2:0]      bc, bc_n;
  logic [7:0]      shreg, shreg_n, data, data_n;
  logic            ready, ready_n, ferr, ferr_n, brk_hi, brk_hi_n;
  logic            rx_m, rx_s, tick, bit_val;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .enable(state != IDLE),
    .tick  (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // sc runs half a bit behind the bit cell, so sc = LAST-2..LAST are the
  // three ticks centred on mid-bit; the last one is the decision tick.
  logic [1:0] votes, votes_n;

  always_comb begin
    votes_n = votes;
    if (tick && (state == DATA || state == STOP)) begin
      if (sc == SC_LAST - SC_W'(2)) votes_n[0] = rx_s;
      if (sc == SC_LAST - SC_W'(1)) votes_n[1] = rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) votes <= '0;
    else      votes <= votes_n;
  end

  assign bit_val = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      state  <= IDLE;
      sc     <= '0;
      bc     <= '0;
      shreg  <= '0;
      data   <= '0;
      ready  <= 1'b0;
      ferr   <= 1'b0;
      brk_hi <= 1'b0;
    end else begin
      rx_m   <= bus.rx;
      rx_s   <= rx_m;
      state  <= state_n;
      sc     <= sc_n;
      bc     <= bc_n;
      shreg  <= shreg_n;
      data   <= data_n;
      ready  <= ready_n;
      ferr   <= ferr_n;
      brk_hi <= brk_hi_n;
    end
  end

  always_comb begin
    state_n  = state;
    sc_n     = sc;
    bc_n     = bc;
    shreg_n  = shreg;
    data_n   = data;
    ready_n  = 1'b0;
    ferr_n   = 1'b0;
    brk_hi_n = brk_hi;
    unique case (state)
      IDLE: begin
        sc_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (tick) begin
        if (sc == SC_HALF) begin
          sc_n    = '0;
          bc_n    = '0;
          state_n = rx_s ? IDLE : DATA;
        end else sc_n = sc + 1'b1;
      end
      DATA: if (tick) begin
        if (sc == SC_LAST) begin
          sc_n    = '0;
          shreg_n = {bit_val, shreg[7:1]};
          bc_n    = bc + 1'b1;
          if (bc == 3'd7) state_n = STOP;
        end else sc_n = sc + 1'b1;
      end
      STOP: if (tick) begin
        if (sc == SC_LAST) begin
          sc_n = '0;
          if (bit_val) begin
            data_n  = shreg;
            ready_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n   = 1'b1;
            brk_hi_n = 1'b0;
            state_n  = BREAK;
          end
        end else sc_n = sc + 1'b1;
      end
      // Line must stay high across a whole tick interval before re-arming.
      BREAK: begin
        if (!rx_s) brk_hi_n = 1'b0;
        else if (tick) begin
          if (brk_hi) state_n = IDLE;
          else        brk_hi_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.data       = data;
  assign bus.dataReady  = ready;
  assign bus.frameError = ferr;
  assign bus.busy       = (state != IDLE);

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
Serial front end of the virtual console. It oversamples the asynchronous UART RX pin and reassembles 8N1 frames (8 data bits, no parity, 1 stop bit). Each good byte is presented to the VT100 parser's dataReady/data inputs as a one-cycle pulse. It sits directly upstream of the escape-sequence parser and holds the only asynchronous-input synchronizer on the console path.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate in baud
OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  raw UART line; idle high; asynchronous to clk
data  output  8  last received byte; held stable until the next good byte
dataReady  output  1  one-cycle pulse; data is valid in this cycle
frameError  output  1  one-cycle pulse when the stop bit samples low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst low, asynchronous): data=8'h00, dataReady=0, frameError=0, busy=0. FSM goes to IDLE, all counters clear, synchronizer flops preset to 1.
- Synchronizer: rx passes through 2 flops to give rx_s. Nothing else reads rx directly.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer division, minimum 1.
  - The counter counts 0..DIV-1 and pulses tick for one clk at wrap.
  - The counter is held at 0 in IDLE, so the start-bit phase is set by the falling edge.
- Sample counter: sc counts 0..OVERSAMPLE-1 in ticks. Bit counter bc is 3 bits.
- FSM states and transitions:
  - IDLE: when rx_s=0, go to START and clear sc.
  - START: on the tick where sc reaches OVERSAMPLE/2-1 (mid start bit), re-sample rx_s.
    - rx_s=1: glitch; return to IDLE with no output pulse.
    - rx_s=0: go to DATA, clear sc and bc.
  - DATA: on each tick where sc reaches OVERSAMPLE-1 (mid bit), shift rx_s into the shift register MSB, so the byte ends LSB-first. Then increment bc. When bc=7 has been sampled, go to STOP.
  - STOP: at mid stop bit (sc=OVERSAMPLE-1):
    - rx_s=1: latch the shift register into data, pulse dataReady on the next clk, go to IDLE.
    - rx_s=0: pulse frameError, leave data unchanged, go to BREAK.
  - BREAK: wait for rx_s=1 held for one full tick period, then go to IDLE. This prevents a held-low line from being decoded as 0x00 bytes.
- Latency: dataReady rises exactly 1 clk after the clock edge carrying the mid-stop-bit tick. That is about 9.5 bit times plus 2 synchronizer clks after the start-bit falling edge.
- dataReady and frameError are mutually exclusive and never high for more than 1 clk.
- Back-to-back frames: IDLE is re-entered from the mid stop bit. A start edge arriving 0.5 bit later is caught with no lost byte.
- No backpressure: the downstream stage consumes a byte in 1 clk.
- Reset mid-frame: the partial byte is discarded and no pulse is produced. After rst is released, reception restarts only on a fresh falling edge.
- The tick counter width is $clog2(DIV)+1.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each data and stop bit is decided by majority vote of 3 samples taken on ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2 within the bit. The state-advance tick and latency are unchanged.
- Undefined: a single sample at mid bit, as described above.
- The start-bit glitch check uses a single sample in both builds.

Decomposition:
- Shared package (DataType.sv): typedef enum UartRxState {IDLE, START, DATA, STOP, BREAK}.
- One sub-module, uart_baud_tick (parameters CLK_FREQ, BAUD_RATE, OVERSAMPLE; ports clk, rst, enable, tick). The FSM, shift register and synchronizer stay in the top module.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16, so DIV=1 and one bit lasts 16 clks.
- Reset: hold rst low with rx toggling -> data=0x00, dataReady=0, busy=0. After release with rx idle high, no pulses for 1000 clks.
- Single frame 0x1B -> exactly one dataReady pulse with data=0x1B, 1 clk after the mid-stop sample. frameError stays 0.
- Back-to-back "[2J" (0x5B 0x32 0x4A) with no idle gap -> three dataReady pulses with the correct bytes, spaced 160 clks apart.
- Start glitch: rx low for 4 clks, then high -> no dataReady, FSM back in IDLE. A following 0x41 is received correctly.
- Framing error: send 0x55 with the stop bit forced low and rx held low for 40 clks -> frameError pulses once, no dataReady, data keeps its old value. After rx goes high, 0x7E is received correctly.
- Reset mid-frame: assert rst during bit 4 of 0xFF -> no pulse. After release, 0x30 is received with data=0x30. Run this with UART_RX_MAJORITY_EN both defined and undefined. Under the majority build, also inject a 1-clk flip at mid bit and check the byte is still correct.
